// File: rtl/sdm_pkg.sv
// Shared types and constants for the stereo SDM datapath sequencing logic.
package sdm_pkg;

    localparam int unsigned AUDIO_DW       = 16;
    localparam int unsigned UNDERRUN_CNT_W = 8;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_PRIME = 2'd1,
        SCHED_RUN   = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic signed [AUDIO_DW-1:0] left;
        logic signed [AUDIO_DW-1:0] right;
    } audio_frame_t;

endpackage

// File: rtl/sdm_tick_gen.sv
// Oversampling tick generator: clock divider plus per-frame tick counter,
// both held at zero while run is low.
module sdm_tick_gen #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned OSR     = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick,
    output logic boundary
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned OSR_W = (OSR > 1) ? $clog2(OSR) : 1;

    logic [DIV_W-1:0] div_q;
    logic [OSR_W-1:0] osr_q;

    // Strobes decode purely from the counter registers and the registered run.
    always_comb begin
        tick     = run && (div_q == DIV_W'(CLK_DIV - 1));
        boundary = tick && (osr_q == OSR_W'(OSR - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            osr_q <= '0;
        end else if (!run) begin
            div_q <= '0;
            osr_q <= '0;
        end else if (tick) begin
            div_q <= '0;
            osr_q <= boundary ? '0 : osr_q + OSR_W'(1);
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/sdm_stream_scheduler.sv
// Stream-to-SDM sequencing controller: frame intake, hold registers and tick strobes.
// Optional saturating underrun counter enabled by SDM_SCHED_UNDERRUN_CNT_EN.
module sdm_stream_scheduler
    import sdm_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned OSR     = 64,
    parameter int unsigned DW      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DW-1:0]             s_left,
    input  logic [DW-1:0]             s_right,
    output logic                      dac_valid,
    output logic [DW-1:0]             dac_left,
    output logic [DW-1:0]             dac_right,
    output logic                      adc_valid,
    output logic                      frame_tick,
    output logic                      underrun,
    output logic [UNDERRUN_CNT_W-1:0] underrun_cnt,
    output logic                      running
);

    sched_state_t state_q, state_d;

    logic          run;
    logic          tick;
    logic          boundary;
    logic          handshake;
    logic          leave_run;
    logic          pend_full;
    logic [DW-1:0] pend_left;
    logic [DW-1:0] pend_right;

    assign run       = (state_q == SCHED_RUN);
    assign handshake = s_valid && s_ready;
    assign leave_run = run && (state_d == SCHED_IDLE);

    sdm_tick_gen #(
        .CLK_DIV (CLK_DIV),
        .OSR     (OSR)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .tick     (tick),
        .boundary (boundary)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCHED_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A handshake in PRIME wins over a simultaneous enable drop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SCHED_IDLE: begin
                if (enable) state_d = SCHED_PRIME;
            end
            SCHED_PRIME: begin
                if (s_valid)      state_d = SCHED_RUN;
                else if (!enable) state_d = SCHED_IDLE;
            end
            SCHED_RUN: begin
                if (boundary && !enable) state_d = SCHED_IDLE;
            end
            default: state_d = SCHED_IDLE;
        endcase
    end

    always_comb begin
        s_ready    = 1'b0;
        running    = 1'b0;
        dac_valid  = 1'b0;
        adc_valid  = 1'b0;
        frame_tick = 1'b0;
        underrun   = 1'b0;
        case (state_q)
            SCHED_PRIME: begin
                s_ready = 1'b1;
            end
            SCHED_RUN: begin
                s_ready    = !pend_full;
                running    = 1'b1;
                dac_valid  = tick;
                adc_valid  = tick;
                frame_tick = boundary && pend_full;
                underrun   = boundary && !pend_full;
            end
            default: ;
        endcase
    end

    // Pending buffer and hold registers; leaving RUN drops everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full  <= 1'b0;
            pend_left  <= '0;
            pend_right <= '0;
            dac_left   <= '0;
            dac_right  <= '0;
        end else if (leave_run) begin
            pend_full  <= 1'b0;
            pend_left  <= '0;
            pend_right <= '0;
            dac_left   <= '0;
            dac_right  <= '0;
        end else if (state_q == SCHED_PRIME) begin
            if (handshake) begin
                dac_left  <= s_left;
                dac_right <= s_right;
            end
        end else if (run) begin
            if (frame_tick) begin
                dac_left  <= pend_left;
                dac_right <= pend_right;
                pend_full <= 1'b0;
            end
            if (handshake) begin
                pend_left  <= s_left;
                pend_right <= s_right;
                pend_full  <= 1'b1;
            end
        end
    end

`ifdef SDM_SCHED_UNDERRUN_CNT_EN
    // Saturating count; survives IDLE, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
        end else if (underrun && (underrun_cnt != {UNDERRUN_CNT_W{1'b1}})) begin
            underrun_cnt <= underrun_cnt + UNDERRUN_CNT_W'(1);
        end
    end
`else
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_sdm_stream_scheduler.sv
// Randomized bench for sdm_stream_scheduler with a frame-level reference model.
module tb_sdm_stream_scheduler;

    localparam int CD = 4;
    localparam int OS = 8;
    localparam int FP = CD * OS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_left = '0;
    logic [15:0] s_right = '0;
    logic        dac_valid;
    logic [15:0] dac_left;
    logic [15:0] dac_right;
    logic        adc_valid;
    logic        frame_tick;
    logic        underrun;
    logic [7:0]  underrun_cnt;
    logic        running;

    sdm_stream_scheduler #(.CLK_DIV(CD), .OSR(OS), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
        .dac_valid(dac_valid), .dac_left(dac_left), .dac_right(dac_right),
        .adc_valid(adc_valid), .frame_tick(frame_tick), .underrun(underrun),
        .underrun_cnt(underrun_cnt), .running(running)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: mode 0 idle, 1 waiting for first frame, 2 streaming.
    // m_k counts cycles since streaming began; ticks and boundaries follow from it.
    int          m_mode = 0;
    int          m_k = 0;
    logic [15:0] m_hl = '0;
    logic [15:0] m_hr = '0;
    logic [31:0] m_pend[$];
    int          m_ucnt = 0;

    function automatic bit m_tick();
        return (m_mode == 2) && ((m_k % CD) == CD - 1);
    endfunction

    function automatic bit m_bnd();
        return (m_mode == 2) && ((m_k % FP) == FP - 1);
    endfunction

    function automatic bit m_ready();
        if (m_mode == 1) return 1'b1;
        if (m_mode == 2) return m_pend.size() == 0;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_hl = '0; m_hr = '0; m_ucnt = 0;
        m_pend.delete();
    endtask

    task automatic model_step();
        bit          hs;
        bit          b;
        logic [31:0] f;
        hs = s_valid && m_ready();
        b  = m_bnd();
        case (m_mode)
            0: if (enable) m_mode = 1;
            1: begin
                if (s_valid) begin
                    m_hl = s_left; m_hr = s_right; m_mode = 2; m_k = 0;
                end else if (!enable) begin
                    m_mode = 0;
                end
            end
            default: begin
                if (b) begin
                    if (m_pend.size() != 0) begin
                        f = m_pend.pop_front();
                        m_hl = f[31:16]; m_hr = f[15:0];
                    end else if (m_ucnt < 255) begin
                        m_ucnt++;
                    end
                end
                if (hs) m_pend.push_back({s_left, s_right});
                if (b && !enable) begin
                    m_mode = 0; m_hl = '0; m_hr = '0; m_k = 0;
                    m_pend.delete();
                end else begin
                    m_k++;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        bit b;
        int exp_ucnt;
        b = m_bnd();
`ifdef SDM_SCHED_UNDERRUN_CNT_EN
        exp_ucnt = m_ucnt;
`else
        exp_ucnt = 0;
`endif
        chk("dac_valid",    32'(dac_valid),    32'(m_tick()));
        chk("adc_valid",    32'(adc_valid),    32'(m_tick()));
        chk("frame_tick",   32'(frame_tick),   32'(b && (m_pend.size() != 0)));
        chk("underrun",     32'(underrun),     32'(b && (m_pend.size() == 0)));
        chk("s_ready",      32'(s_ready),      32'(m_ready()));
        chk("running",      32'(running),      32'(m_mode == 2));
        chk("dac_left",     32'(dac_left),     32'(m_hl));
        chk("dac_right",    32'(dac_right),    32'(m_hr));
        chk("underrun_cnt", 32'(underrun_cnt), 32'(exp_ucnt));
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        check_outputs();
    end

    // Stimulus helpers: inputs change on the falling edge only.
    bit          hs = 1'b0;
    int          data = 0;
    logic [15:0] last_acc = '0;
    bit          obs_ft, obs_ur, obs_dv;

    task automatic sync();
        @(negedge clk);
        if (hs) data = int'($urandom_range(0, 65535));
        obs_ft = frame_tick;
        obs_ur = underrun;
        obs_dv = dac_valid;
    endtask

    task automatic drive(input bit v);
        s_valid = v;
        s_left  = 16'(data);
        s_right = ~16'(data);
        hs = v && s_ready;
        if (hs) last_acc = 16'(data);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, ft, ur, gap, last, dv_cnt, ev;

        // Reset and idle
        #2;
        chk("reset_dac_left", 32'(dac_left), 32'h0);
        chk("reset_s_ready", 32'(s_ready), 32'h0);
        chk("reset_ucnt", 32'(underrun_cnt), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) begin sync(); drive(1'b0); end

        // Prime with L=0x1234, R=-5
        sync(); enable = 1'b1; drive(1'b0);
        sync();
        chk("prime_s_ready", 32'(s_ready), 32'h1);
        data = 16'h1234; drive(1'b1); s_right = 16'hFFFB;
        sync(); drive(1'b0);
        chk("prime_dac_left", 32'(dac_left), 32'h1234);
        chk("prime_dac_right", 32'(dac_right), 32'hFFFB);
        chk("prime_running", 32'(running), 32'h1);
        n = 0;
        while (!dac_valid && n < 10) begin sync(); drive(1'b0); n++; end
        chk("first_tick_latency", 32'(n), 32'd3);
        n = 0;
        do begin sync(); drive(1'b0); n++; end while (!obs_dv && n < 10);
        chk("tick_period", 32'(n), 32'd4);

        // Steady stream
        ft = 0; ur = 0; gap = 0; last = -1;
        for (int i = 0; i < 128; i++) begin
            sync(); drive(1'b1);
            if (obs_ft) begin
                if (last >= 0 && i - last != FP) gap++;
                last = i; ft++;
            end
            if (obs_ur) ur++;
        end
        chk("steady_frames", 32'(ft), 32'd4);
        chk("steady_underruns", 32'(ur), 32'd0);
        chk("steady_frame_gap", 32'(gap), 32'd0);

        // Underrun: align to a boundary, refill once, then withhold
        n = 0;
        do begin sync(); drive(1'b1); n++; end while (!obs_ft && n < 64);
        chk("underrun_align", 32'(obs_ft), 32'h1);
        sync(); drive(1'b1);
        ft = 0; ur = 0;
        repeat (96) begin sync(); drive(1'b0); ft += int'(obs_ft); ur += int'(obs_ur); end
        chk("withhold_frames", 32'(ft), 32'd1);
        chk("withhold_underruns", 32'(ur), 32'd2);
        chk("withhold_hold", 32'(dac_left), 32'(last_acc));
`ifdef SDM_SCHED_UNDERRUN_CNT_EN
        chk("withhold_ucnt", 32'(underrun_cnt), 32'd2);
`else
        chk("withhold_ucnt", 32'(underrun_cnt), 32'd0);
`endif

        // Frame presented on the boundary cycle itself
        n = 0;
        do begin sync(); drive(1'b0); n++; end while (!m_bnd() && n < 64);
        drive(1'b1);
        chk("boundary_frame_underrun", 32'(obs_ur), 32'h1);
        n = 0;
        do begin sync(); drive(1'b0); n++; end while (!obs_ft && n < 40);
        chk("boundary_frame_delay", 32'(n), 32'd32);
        sync(); drive(1'b0);
        chk("boundary_frame_loaded", 32'(dac_left), 32'(last_acc));

        // Disable during tick 3 with a pending frame
        n = 0;
        do begin sync(); drive(1'b1); n++; end while (!(m_mode == 2 && (m_k % FP) == 15) && n < 100);
        enable = 1'b0;
        dv_cnt = int'(obs_dv);
        n = 0;
        while (m_mode == 2 && n < 40) begin sync(); drive(1'b0); dv_cnt += int'(obs_dv); n++; end
        chk("disable_ticks", 32'(dv_cnt), 32'd5);
        chk("disable_idle", 32'(running), 32'h0);
        chk("disable_dac_left", 32'(dac_left), 32'h0);

        // Randomized traffic with occasional enable drops
        repeat (600) begin
            sync();
            enable = ($urandom_range(0, 99) < 97);
            drive($urandom_range(0, 99) < 60);
        end

        // Asynchronous reset between ticks
        n = 0;
        do begin sync(); enable = 1'b1; drive(1'b1); n++; end
        while (!(m_mode == 2 && (m_k % CD) == 1 && m_k >= FP) && n < 300);
        #2 rst_n = 1'b0;
        hs = 1'b0;
        #1;
        chk("areset_dac_left", 32'(dac_left), 32'h0);
        chk("areset_running", 32'(running), 32'h0);
        chk("areset_s_ready", 32'(s_ready), 32'h0);
        chk("areset_dac_valid", 32'(dac_valid), 32'h0);
        sync(); drive(1'b0);
        sync(); drive(1'b0);
        rst_n = 1'b1;
        ev = 0;
        repeat (40) begin
            sync(); drive(1'b0);
            ev += int'(obs_dv) + int'(obs_ft) + int'(obs_ur) + int'(running);
        end
        chk("post_reset_no_strobes", 32'(ev), 32'd0);
        sync(); data = 16'h0BEE; drive(1'b1);
        sync(); drive(1'b0);
        chk("reprime_dac_left", 32'(dac_left), 32'h0BEE);
        chk("reprime_running", 32'(running), 32'h1);
        repeat (40) begin sync(); drive(1'b1); end
        sync(); drive(1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
